// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants and capture-FSM state encoding for the UART receive buffer.
package uart_rx_fifo_pkg;

  localparam int unsigned UART_RX_DEPTH  = 16;
  localparam int unsigned UART_RX_ADDR_W = $clog2(UART_RX_DEPTH);

  typedef enum logic [1:0] {
    CapIdle  = 2'd0,
    CapClear = 2'd1,
    CapWait  = 2'd2
  } cap_state_e;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Generic single-clock first-word-fall-through FIFO with occupancy count.
module sync_fifo_fwft #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [AddrW:0]   count_o
);

  localparam int unsigned CntW = AddrW + 1;
  localparam logic [AddrW:0]   DepthCnt = CntW'(Depth);
  localparam logic [AddrW:0]   CntOne   = CntW'(1);
  localparam logic [AddrW-1:0] PtrOne   = AddrW'(1);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DepthCnt);
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side buffer: captures each ready byte from the receiver, pulses its clear,
// and queues the byte in a FWFT FIFO with a sticky overflow flag.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH  = UART_RX_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_ready_i,
  input  logic [7:0]        rx_data_i,
  output logic              rx_clear_o,
  input  logic              pop_i,
  output logic [7:0]        data_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [ADDR_W:0]   count_o,
  output logic              overflow_o,
  input  logic              clr_ovf_i
);

  cap_state_e state_q, state_d;
  logic       push;
  logic       drop;
  logic       ovf_q;

  always_comb begin
    state_d    = state_q;
    rx_clear_o = 1'b0;
    push       = 1'b0;
    drop       = 1'b0;
    unique case (state_q)
      CapIdle: begin
        if (rx_ready_i) begin
          if (full_o && !pop_i) drop = 1'b1;
          else                  push = 1'b1;
          state_d = CapClear;
        end
      end
      CapClear: begin
        rx_clear_o = 1'b1;
        state_d    = CapWait;
      end
      CapWait: begin
        // Hold off until the receiver drops ready so one byte yields one push.
        if (!rx_ready_i) state_d = CapIdle;
      end
      default: state_d = CapIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= CapIdle;
    else     state_q <= state_d;
  end

  // Set has priority so a drop coinciding with a clear is never lost.
  always_ff @(posedge clk) begin
    if (rst)            ovf_q <= 1'b0;
    else if (drop)      ovf_q <= 1'b1;
    else if (clr_ovf_i) ovf_q <= 1'b0;
  end

  assign overflow_o = ovf_q;

  sync_fifo_fwft #(
    .Width (8),
    .Depth (DEPTH),
    .AddrW (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (rx_data_i),
    .pop_i   (pop_i),
    .rdata_o (data_o),
    .empty_o (empty_o),
    .full_o  (full_o),
    .count_o (count_o)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model plus per-cycle monitor.
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx_ready_i = 1'b0;
  logic [7:0]        rx_data_i = 8'h00;
  logic              rx_clear_o;
  logic              pop_i = 1'b0;
  logic [7:0]        data_o;
  logic              empty_o;
  logic              full_o;
  logic [ADDR_W:0]   count_o;
  logic              overflow_o;
  logic              clr_ovf_i = 1'b0;

  int  checks = 0;
  int  errors = 0;
  int  sent_bytes = 0;
  int  clear_pulses = 0;
  bit  cap_now = 1'b0;
  bit  pop_en = 1'b0;
  bit  started = 1'b0;
  byte unsigned model_q[$];
  bit  model_ovf = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_ready_i (rx_ready_i),
    .rx_data_i  (rx_data_i),
    .rx_clear_o (rx_clear_o),
    .pop_i      (pop_i),
    .data_o     (data_o),
    .empty_o    (empty_o),
    .full_o     (full_o),
    .count_o    (count_o),
    .overflow_o (overflow_o),
    .clr_ovf_i  (clr_ovf_i)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the FIFO is a plain queue; a byte offered while full with no
  // effective pop is dropped and latches overflow.
  initial begin
    bit pop_eff;
    bit drop;
    forever begin
      @(posedge clk);
      if (rst) begin
        model_q.delete();
        model_ovf = 1'b0;
      end else begin
        pop_eff = pop_i && (model_q.size() > 0);
        drop    = cap_now && (model_q.size() == DEPTH) && !pop_eff;
        if (pop_eff) void'(model_q.pop_front());
        if (cap_now && !drop) model_q.push_back(rx_data_i);
        if (drop)           model_ovf = 1'b1;
        else if (clr_ovf_i) model_ovf = 1'b0;
      end
      started = 1'b1;
    end
  end

  // Monitor: compare every visible output against the model away from the clock edge.
  initial begin
    int exp_head;
    forever begin
      @(negedge clk);
      if (started) begin
        exp_head = (model_q.size() > 0) ? int'(model_q[0]) : 0;
        chk("count", 32'(count_o), 32'(model_q.size()));
        chk("empty", 32'(empty_o), 32'(model_q.size() == 0));
        chk("full", 32'(full_o), 32'(model_q.size() == DEPTH));
        chk("overflow", 32'(overflow_o), 32'(model_ovf));
        chk("head", 32'(data_o), 32'(exp_head));
        if (rx_clear_o) clear_pulses++;
      end
    end
  end

  // Background random consumer and overflow clears.
  initial begin
    forever begin
      step();
      if (pop_en) begin
        pop_i     = ($urandom_range(0, 2) == 0);
        clr_ovf_i = ($urandom_range(0, 15) == 0);
      end
    end
  end

  task automatic wait_clear();
    int n = 0;
    while (!rx_clear_o && n < 4) begin
      step();
      n++;
    end
    chk("clear_seen", 32'(rx_clear_o), 32'd1);
    chk("clear_latency", 32'(n), 32'd0);
  endtask

  // Behaves like async_receiver: hold ready until cleared, then drop it.
  task automatic send(input logic [7:0] b, input bit with_pop, input bit with_clr);
    rx_ready_i = 1'b1;
    rx_data_i  = b;
    cap_now    = 1'b1;
    if (with_pop) pop_i = 1'b1;
    if (with_clr) clr_ovf_i = 1'b1;
    step();
    cap_now = 1'b0;
    if (with_pop) pop_i = 1'b0;
    if (with_clr) clr_ovf_i = 1'b0;
    sent_bytes++;
    wait_clear();
    rx_ready_i = 1'b0;
    step();
    chk("clear_width", 32'(rx_clear_o), 32'd0);
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_data", 32'(data_o), 32'h00);
    chk("rst_clear", 32'(rx_clear_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    pop_i = 1'b1;
    repeat (2) step();
    pop_i = 1'b0;
    step();
    chk("idle_pop_count", 32'(count_o), 32'd0);

    send(8'h41, 1'b0, 1'b0);
    chk("single_data", 32'(data_o), 32'h41);
    chk("single_count", 32'(count_o), 32'd1);
    pop_i = 1'b1;
    step();
    pop_i = 1'b0;
    chk("single_pop_empty", 32'(empty_o), 32'd1);

    for (int i = 0; i < 16; i++) send(8'(i), 1'b0, 1'b0);
    chk("burst_full", 32'(full_o), 32'd1);
    chk("burst_count", 32'(count_o), 32'd16);
    chk("burst_ovf", 32'(overflow_o), 32'd0);
    pop_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("burst_order", 32'(data_o), 32'(i));
      step();
    end
    pop_i = 1'b0;
    chk("burst_drained", 32'(empty_o), 32'd1);

    for (int i = 0; i < 16; i++) send(8'(i), 1'b0, 1'b0);
    send(8'hAA, 1'b0, 1'b0);
    chk("ovf_set", 32'(overflow_o), 32'd1);
    chk("ovf_count", 32'(count_o), 32'd16);
    chk("ovf_head", 32'(data_o), 32'h00);
    send(8'hBB, 1'b0, 1'b1);
    chk("ovf_set_wins", 32'(overflow_o), 32'd1);
    clr_ovf_i = 1'b1;
    step();
    clr_ovf_i = 1'b0;
    chk("ovf_cleared", 32'(overflow_o), 32'd0);

    send(8'h55, 1'b1, 1'b0);
    chk("full_pp_ovf", 32'(overflow_o), 32'd0);
    chk("full_pp_count", 32'(count_o), 32'd16);
    pop_i = 1'b1;
    for (int i = 1; i < 16; i++) begin
      chk("full_pp_order", 32'(data_o), 32'(i));
      step();
    end
    pop_i = 1'b0;
    chk("full_pp_head", 32'(data_o), 32'h55);
    pop_i = 1'b1;
    step();
    pop_i = 1'b0;

    // Reset while the FSM is in its clear state with ready still held high.
    rx_ready_i = 1'b1;
    rx_data_i  = 8'h77;
    cap_now    = 1'b1;
    step();
    cap_now = 1'b0;
    chk("midcap_in_clear", 32'(rx_clear_o), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midcap_rst_count", 32'(count_o), 32'd0);
    cap_now = 1'b1;
    step();
    cap_now = 1'b0;
    sent_bytes += 2;
    wait_clear();
    rx_ready_i = 1'b0;
    repeat (2) step();
    chk("midcap_count", 32'(count_o), 32'd1);
    chk("midcap_data", 32'(data_o), 32'h77);
    pop_i = 1'b1;
    step();
    pop_i = 1'b0;

    pop_en = 1'b1;
    repeat (150) begin
      send(8'($urandom_range(0, 255)), 1'b0, 1'b0);
      repeat ($urandom_range(0, 3)) step();
    end
    pop_en = 1'b0;
    step();
    clr_ovf_i = 1'b0;
    pop_i     = 1'b1;
    repeat (DEPTH + 2) step();
    pop_i = 1'b0;
    step();
    chk("final_empty", 32'(empty_o), 32'd1);
    chk("clear_pulses", 32'(clear_pulses), 32'(sent_bytes));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
